transfer_sequencer: RTL and testbench

Central controller for the UART-receive → FIFO → output → inter-board transfer chain. It replaces free-running stage enables with a sequenced flow: IDLE → CLEAR → RECEIVE → DRAIN → DONE/ERROR. It drives the enables and a synchronous clear for the COM-to-FIFO and FIFO-to-out stages, counts bytes moved, and detects errors, overflow and stalls. It sits at the top level between the single-pulsed push-button and the stage structures, in the UART clock domain.

---
 rtl/transfer_seq_pkg.sv | 23 ++
 rtl/sat_counter.sv | 27 ++
 rtl/transfer_sequencer.sv | 168 ++++++++++++++++
 tb/tb_transfer_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transfer_seq_pkg.sv
// Shared definitions for the transfer sequencer: state encoding, error causes
// and datapath widths used by the controller and its counters.
package transfer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RECEIVE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam int COUNT_WIDTH = 10;
  localparam int TIMER_WIDTH = 12;
  localparam int ERR_WIDTH   = 4;

  localparam logic [ERR_WIDTH-1:0] ERR_NONE       = 4'h0;
  localparam logic [ERR_WIDTH-1:0] ERR_OVERFLOW   = 4'hF;
  localparam logic [ERR_WIDTH-1:0] ERR_RX_TIMEOUT = 4'hE;
  localparam logic [ERR_WIDTH-1:0] ERR_TX_TIMEOUT = 4'hD;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so a runaway transfer never reports a small byte count.
module sat_counter
  import transfer_seq_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX_COUNT)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/transfer_sequencer.sv
// Sequences the UART-receive -> FIFO -> output chain: clears the stages, runs
// receive then drain, and reports completion, errors, overflow and stalls.
module transfer_sequencer
  import transfer_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CLEAR_CYCLES   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   com_finish,
  input  logic [ERR_WIDTH-1:0]   com_error,
  input  logic                   fifo_we,
  input  logic                   fifo_re,
  input  logic                   fifo_empty,
  input  logic                   fifo_full,
  input  logic                   out_finish,
  output logic                   com_enable,
  output logic                   out_enable,
  output logic                   stage_clear,
  output logic                   busy,
  output logic                   done,
  output logic                   error_flag,
  output logic [ERR_WIDTH-1:0]   error_code,
  output logic [COUNT_WIDTH-1:0] rx_count,
  output logic [COUNT_WIDTH-1:0] tx_count,
  output logic [2:0]             state
);

  localparam int CLEAR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLEAR_W-1:0]     CLEAR_LAST  = CLEAR_W'(CLEAR_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL = TIMER_WIDTH'(TIMEOUT_CYCLES);

  state_t                 cur_state;
  state_t                 next_state;
  logic [ERR_WIDTH-1:0]   next_error;
  logic [TIMER_WIDTH-1:0] timer;
  logic [CLEAR_W-1:0]     clear_cnt;
  logic                   timeout_hit;
  logic                   enter_clear;
  logic                   activity;
  logic                   rx_inc;
  logic                   tx_inc;

  assign timeout_hit = (timer == TIMEOUT_VAL);
  assign enter_clear = (next_state == ST_CLEAR) && (cur_state != ST_CLEAR);
  assign rx_inc      = (cur_state == ST_RECEIVE) && fifo_we;
  assign tx_inc      = (cur_state == ST_DRAIN) && fifo_re;
  assign activity    = rx_inc || tx_inc;
  assign state       = cur_state;

  // A nonzero COM error outranks overflow, which outranks a clean finish;
  // the stall timeout is the weakest cause. abort beats everything.
  always_comb begin
    next_state = cur_state;
    next_error = error_code;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (start) next_state = ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clear_cnt == CLEAR_LAST) next_state = ST_RECEIVE;
        end
        ST_RECEIVE: begin
          if (com_finish && (com_error != ERR_NONE)) begin
            next_state = ST_ERROR;
            next_error = com_error;
          end else if (fifo_full && fifo_we) begin
            next_state = ST_ERROR;
            next_error = ERR_OVERFLOW;
          end else if (com_finish) begin
            next_state = fifo_empty ? ST_DONE : ST_DRAIN;
          end else if (timeout_hit) begin
            next_state = ST_ERROR;
            next_error = ERR_RX_TIMEOUT;
          end
        end
        ST_DRAIN: begin
          if (out_finish && fifo_empty) begin
            next_state = ST_DONE;
          end else if (timeout_hit) begin
            next_state = ST_ERROR;
            next_error = ERR_TX_TIMEOUT;
          end
        end
        ST_DONE: begin
          next_state = ST_IDLE;
        end
        ST_ERROR: begin
          if (start) next_state = ST_CLEAR;
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
    if (enter_clear) next_error = ERR_NONE;
  end

  // Outputs are decoded from next_state so they change on the same edge as
  // the state register, keeping them Moore-registered without a lag cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state   <= ST_IDLE;
      com_enable  <= 1'b0;
      out_enable  <= 1'b0;
      stage_clear <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error_flag  <= 1'b0;
      error_code  <= ERR_NONE;
      timer       <= '0;
      clear_cnt   <= '0;
    end else begin
      cur_state   <= next_state;
      com_enable  <= (next_state == ST_RECEIVE);
      out_enable  <= (next_state == ST_DRAIN);
      stage_clear <= (next_state == ST_CLEAR);
      busy        <= (next_state != ST_IDLE);
      done        <= (next_state == ST_DONE);
      error_flag  <= (next_state == ST_ERROR);
      error_code  <= next_error;

      if (enter_clear) begin
        clear_cnt <= '0;
      end else if (cur_state == ST_CLEAR) begin
        clear_cnt <= clear_cnt + CLEAR_W'(1);
      end

      // Each stage starts its stall window fresh; idle cycles saturate at the limit.
      if (next_state != cur_state) begin
        timer <= '0;
      end else if ((cur_state == ST_RECEIVE) || (cur_state == ST_DRAIN)) begin
        if (activity) begin
          timer <= '0;
        end else if (!timeout_hit) begin
          timer <= timer + TIMER_WIDTH'(1);
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_rx_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (enter_clear),
    .inc     (rx_inc),
    .count   (rx_count)
  );

  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_tx_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (enter_clear),
    .inc     (tx_inc),
    .count   (tx_count)
  );

endmodule

// File: tb/tb_transfer_sequencer.sv
// Directed self-checking bench for transfer_sequencer: normal flow, error
// causes, stall timeouts and their boundary, abort, saturation and async reset.
module tb_transfer_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       com_finish;
  logic [3:0] com_error;
  logic       fifo_we;
  logic       fifo_re;
  logic       fifo_empty;
  logic       fifo_full;
  logic       out_finish;
  logic       com_enable;
  logic       out_enable;
  logic       stage_clear;
  logic       busy;
  logic       done;
  logic       error_flag;
  logic [3:0] error_code;
  logic [9:0] rx_count;
  logic [9:0] tx_count;
  logic [2:0] state;

  int checks;
  int failures;

  transfer_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .com_finish  (com_finish),
    .com_error   (com_error),
    .fifo_we     (fifo_we),
    .fifo_re     (fifo_re),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .out_finish  (out_finish),
    .com_enable  (com_enable),
    .out_enable  (out_enable),
    .stage_clear (stage_clear),
    .busy        (busy),
    .done        (done),
    .error_flag  (error_flag),
    .error_code  (error_code),
    .rx_count    (rx_count),
    .tx_count    (tx_count),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start and walk through the four CLEAR cycles into RECEIVE.
  task automatic go_receive(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL %s_enter_receive state got=%0d exp=2", tag, state);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 0; abort = 0; com_finish = 0; com_error = 4'h0;
    fifo_we = 0; fifo_re = 0; fifo_empty = 1; fifo_full = 0; out_finish = 0;
    #12;
    checks++;
    if ({com_enable, out_enable, stage_clear, busy, done, error_flag} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000",
               {com_enable, out_enable, stage_clear, busy, done, error_flag});
    end
    checks++;
    if ({state, error_code, rx_count, tx_count} !== 27'd0) begin
      failures++;
      $display("FAIL reset_regs state=%0d code=%0h rx=%0d tx=%0d exp all 0",
               state, error_code, rx_count, tx_count);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_normal_flow();
    int clear_high;
    fifo_empty = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    clear_high = 0;
    for (int i = 0; i < 6; i++) begin
      if (stage_clear === 1'b1) clear_high++;
      if (state !== 3'd1) break;
      step();
    end
    checks++;
    if (clear_high !== 4) begin
      failures++;
      $display("FAIL norm_clear_len got=%0d exp=4", clear_high);
    end
    checks++;
    if (state !== 3'd2 || com_enable !== 1'b1 || stage_clear !== 1'b0) begin
      failures++;
      $display("FAIL norm_receive state=%0d com_en=%b clr=%b exp 2/1/0",
               state, com_enable, stage_clear);
    end
    fifo_we = 1'b1;
    repeat (3) step();
    fifo_we = 1'b0;
    checks++;
    if (rx_count !== 10'd3) begin
      failures++;
      $display("FAIL norm_rx_count got=%0d exp=3", rx_count);
    end
    com_finish = 1'b1;
    step();
    com_finish = 1'b0;
    checks++;
    if (state !== 3'd3 || out_enable !== 1'b1 || com_enable !== 1'b0) begin
      failures++;
      $display("FAIL norm_drain state=%0d out_en=%b com_en=%b exp 3/1/0",
               state, out_enable, com_enable);
    end
    fifo_re = 1'b1;
    repeat (3) step();
    fifo_re = 1'b0;
    fifo_empty = 1'b1;
    out_finish = 1'b1;
    step();
    out_finish = 1'b0;
    checks++;
    if (done !== 1'b1 || state !== 3'd4) begin
      failures++;
      $display("FAIL norm_done_pulse done=%b state=%0d exp 1/4", done, state);
    end
    step();
    checks++;
    if (done !== 1'b0 || state !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL norm_idle done=%b state=%0d busy=%b exp 0/0/0", done, state, busy);
    end
    checks++;
    if (rx_count !== 10'd3 || tx_count !== 10'd3) begin
      failures++;
      $display("FAIL norm_counts rx=%0d tx=%0d exp 3/3", rx_count, tx_count);
    end
  endtask

  task automatic test_com_error();
    fifo_empty = 1'b0;
    go_receive("cerr");
    com_finish = 1'b1;
    com_error = 4'h3;
    step();
    com_finish = 1'b0;
    com_error = 4'h0;
    checks++;
    if (state !== 3'd5 || error_flag !== 1'b1 || error_code !== 4'h3) begin
      failures++;
      $display("FAIL cerr_error state=%0d flag=%b code=%0h exp 5/1/3",
               state, error_flag, error_code);
    end
    checks++;
    if (com_enable !== 1'b0 || out_enable !== 1'b0) begin
      failures++;
      $display("FAIL cerr_enables com=%b out=%b exp 0/0", com_enable, out_enable);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || error_code !== 4'h0 || error_flag !== 1'b0) begin
      failures++;
      $display("FAIL cerr_restart state=%0d code=%0h flag=%b exp 1/0/0",
               state, error_code, error_flag);
    end
    repeat (4) step();
  endtask

  task automatic test_overflow();
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL ovf_pre_state got=%0d exp=2", state);
    end
    fifo_we = 1'b1;
    fifo_full = 1'b1;
    step();
    fifo_we = 1'b0;
    fifo_full = 1'b0;
    checks++;
    if (state !== 3'd5 || error_code !== 4'hF) begin
      failures++;
      $display("FAIL ovf_error state=%0d code=%0h exp 5/f", state, error_code);
    end
  endtask

  task automatic test_timeouts();
    fifo_empty = 1'b0;
    go_receive("rxto");
    repeat (4095) step();
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL rxto_early state got=%0d exp=2", state);
    end
    step();
    checks++;
    if (state !== 3'd5 || error_code !== 4'hE) begin
      failures++;
      $display("FAIL rxto_error state=%0d code=%0h exp 5/e", state, error_code);
    end
    go_receive("rxkeep");
    repeat (4093) step();
    fifo_we = 1'b1;
    step();
    fifo_we = 1'b0;
    repeat (5) step();
    checks++;
    if (state !== 3'd2 || error_flag !== 1'b0) begin
      failures++;
      $display("FAIL rxkeep_no_error state=%0d flag=%b exp 2/0", state, error_flag);
    end
    com_finish = 1'b1;
    step();
    com_finish = 1'b0;
    repeat (4095) step();
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL txto_early state got=%0d exp=3", state);
    end
    step();
    checks++;
    if (state !== 3'd5 || error_code !== 4'hD) begin
      failures++;
      $display("FAIL txto_error state=%0d code=%0h exp 5/d", state, error_code);
    end
  endtask

  task automatic test_abort();
    fifo_empty = 1'b0;
    go_receive("abort");
    com_finish = 1'b1;
    step();
    com_finish = 1'b0;
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (state !== 3'd0 || out_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle state=%0d out_en=%b done=%b busy=%b exp 0/0/0/0",
               state, out_enable, done, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || state !== 3'd0) begin
      failures++;
      $display("FAIL abort_no_done done=%b state=%0d exp 0/0", done, state);
    end
  endtask

  task automatic test_saturation_and_reset();
    fifo_empty = 1'b0;
    go_receive("sat");
    fifo_we = 1'b1;
    repeat (1030) step();
    fifo_we = 1'b0;
    checks++;
    if (rx_count !== 10'd1023 || state !== 3'd2) begin
      failures++;
      $display("FAIL sat_rx_count rx=%0d state=%0d exp 1023/2", rx_count, state);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || com_enable !== 1'b0 || busy !== 1'b0 ||
        rx_count !== 10'd0 || stage_clear !== 1'b0) begin
      failures++;
      $display("FAIL async_reset state=%0d com_en=%b busy=%b rx=%0d clr=%b exp all 0",
               state, com_enable, busy, rx_count, stage_clear);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (state !== 3'd0 || stage_clear !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle state=%0d clr=%b exp 0/0", state, stage_clear);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_normal_flow();
    test_com_error();
    test_overflow();
    test_timeouts();
    test_abort();
    test_saturation_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
